// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified Memory port between the instruction-fetch
//   requester (IF) and the data load/store requester (D). Each accepted
//   request is sequenced as IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (one
//   cycle). A misaligned request (when ALIGN_CHECK = 1) skips ACCESS and
//   returns an error response without touching Memory.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req, if_addr             fetch request and address
//   if_ready                    fetch can be accepted this cycle
//   if_valid, if_inst, if_err   fetch response pulse, instruction, error
//   d_req, d_we, d_addr,
//   d_wdata                     data request, store flag, address, store data
//   d_ready                     data request can be accepted this cycle
//   d_valid, d_rdata, d_err     data response pulse, load data, error
//   memRead, memWrite, IRWrite  Memory strobes (mutually exclusive)
//   address, writeData          Memory address / store data
//   readData, readInst          Memory read results
//   busy                        arbiter is in a state other than IDLE
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        memRead,
  output logic        memWrite,
  output logic        IRWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData,
  input  logic [31:0] readInst,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state, stateNext;
  grant_t      lastGrant;
  grant_t      curGrant;
  logic        curWe;
  logic        curErr;
  logic [31:0] curAddr;
  logic [31:0] curWdata;
  logic [3:0]  cnt;
  logic [31:0] ifInstReg;
  logic [31:0] dRdataReg;

  logic        pickIf;
  logic        accept;
  logic [31:0] acceptAddr;
  logic        misaligned;
  logic        lastAccess;
  logic        inAccess;
  logic        inResp;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    pickIf     = if_req && (!d_req || (lastGrant == GRANT_D));
    accept     = (state == IDLE) && (if_req || d_req);
    acceptAddr = pickIf ? if_addr : d_addr;
    misaligned = ALIGN_CHECK && (acceptAddr[1:0] != 2'b00);
    lastAccess = (state == ACCESS) && (cnt == 4'd0);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (lastAccess) begin
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant <= GRANT_D;
      curGrant  <= GRANT_IF;
      curWe     <= 1'b0;
      curErr    <= 1'b0;
      curAddr   <= '0;
      curWdata  <= '0;
      cnt       <= '0;
      ifInstReg <= '0;
      dRdataReg <= '0;
    end else begin
      if (accept) begin
        curGrant  <= pickIf ? GRANT_IF : GRANT_D;
        lastGrant <= pickIf ? GRANT_IF : GRANT_D;
        curAddr   <= acceptAddr;
        curWe     <= pickIf ? 1'b0 : d_we;
        curWdata  <= pickIf ? '0 : d_wdata;
        curErr    <= misaligned;
        cnt       <= CNT_LOAD;
        // Error responses present zero data on the matching output.
        if (misaligned) begin
          if (pickIf) begin
            ifInstReg <= '0;
          end else begin
            dRdataReg <= '0;
          end
        end
      end
      if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (curGrant == GRANT_IF) begin
          ifInstReg <= readInst;
        end else begin
          dRdataReg <= curWe ? '0 : readData;
        end
      end
    end
  end

  always_comb begin
    inAccess  = (state == ACCESS);
    inResp    = (state == RESP);
    IRWrite   = inAccess && (curGrant == GRANT_IF);
    memRead   = inAccess && (curGrant == GRANT_D) && !curWe;
    memWrite  = inAccess && (curGrant == GRANT_D) && curWe;
    address   = inAccess ? curAddr : '0;
    writeData = memWrite ? curWdata : '0;
    if_valid  = inResp && (curGrant == GRANT_IF);
    d_valid   = inResp && (curGrant == GRANT_D);
    if_err    = if_valid && curErr;
    d_err     = d_valid && curErr;
    if_inst   = ifInstReg;
    d_rdata   = dRdataReg;
    // Gated by rst_n so ready is also 0 while reset is held.
    if_ready  = rst_n && (state == IDLE);
    d_ready   = rst_n && (state == IDLE);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct {
    bit          isIf;
    int          kind;      // 0 none, 1 IRWrite, 2 memRead, 3 memWrite
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    bit          err;
    int          strobeCyc;
    int          busyCyc;
  } exp_t;

  logic        clk;
  logic [1:0]  rstN;
  logic [1:0]  ifReq, ifReady, ifValid, ifErr;
  logic [1:0]  dReq, dWe, dReady, dValid, dErr;
  logic [1:0]  memRead, memWrite, IRWrite, busy;
  logic [31:0] ifAddr [2];
  logic [31:0] ifInst [2];
  logic [31:0] dAddr [2];
  logic [31:0] dWdata [2];
  logic [31:0] dRdata [2];
  logic [31:0] address [2];
  logic [31:0] writeData [2];
  logic [31:0] readData [2];
  logic [31:0] readInst [2];
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic        preload;

  int checks = 0;
  int errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int runLen [2];
  int busyRun [2];
  int seenKind [2];
  int respCnt [2];
  logic [31:0] seenAddr [2];
  logic [31:0] seenWd [2];

  mem_port_arbiter #(.MEM_LATENCY(1), .ALIGN_CHECK(1'b1)) u0 (
    .clk(clk), .rst_n(rstN[0]),
    .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_ready(ifReady[0]),
    .if_valid(ifValid[0]), .if_inst(ifInst[0]), .if_err(ifErr[0]),
    .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
    .d_ready(dReady[0]), .d_valid(dValid[0]), .d_rdata(dRdata[0]), .d_err(dErr[0]),
    .memRead(memRead[0]), .memWrite(memWrite[0]), .IRWrite(IRWrite[0]),
    .address(address[0]), .writeData(writeData[0]),
    .readData(readData[0]), .readInst(readInst[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .ALIGN_CHECK(1'b1)) u1 (
    .clk(clk), .rst_n(rstN[1]),
    .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_ready(ifReady[1]),
    .if_valid(ifValid[1]), .if_inst(ifInst[1]), .if_err(ifErr[1]),
    .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
    .d_ready(dReady[1]), .d_valid(dValid[1]), .d_rdata(dRdata[1]), .d_err(dErr[1]),
    .memRead(memRead[1]), .memWrite(memWrite[1]), .IRWrite(IRWrite[1]),
    .address(address[1]), .writeData(writeData[1]),
    .readData(readData[1]), .readInst(readInst[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple word-addressed Memory models, one per arbiter instance.
  assign readData[0] = mem0[address[0][7:2]];
  assign readInst[0] = mem0[address[0][7:2]];
  assign readData[1] = mem1[address[1][7:2]];
  assign readInst[1] = mem1[address[1][7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      mem0[4] <= 32'h00400020;
      mem1[1] <= 32'hCAFEF00D;
      mem1[2] <= 32'h12345678;
    end else begin
      if (memWrite[0]) mem0[address[0][7:2]] <= writeData[0];
      if (memWrite[1]) mem1[address[1][7:2]] <= writeData[1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit isIf, input int kind, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] data,
                              input bit err, input int strobeCyc, input int busyCyc);
    exp_t e;
    e.isIf = isIf; e.kind = kind; e.addr = addr; e.wdata = wdata; e.data = data;
    e.err = err; e.strobeCyc = strobeCyc; e.busyCyc = busyCyc;
    return e;
  endfunction

  task automatic pushExp(input int p, input exp_t e);
    if (p == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Monitor: samples on the falling edge and compares every response
  // against the next scoreboard entry.
  initial begin
    exp_t e;
    bit   have;
    for (int p = 0; p < 2; p++) begin
      runLen[p] = 0; busyRun[p] = 0; seenKind[p] = 0; respCnt[p] = 0;
      seenAddr[p] = '0; seenWd[p] = '0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!rstN[p]) begin
          runLen[p] = 0; busyRun[p] = 0; seenKind[p] = 0;
        end else begin
          if (IRWrite[p] || memRead[p] || memWrite[p]) begin
            chk($sformatf("strobe_onehot%0d", p),
                32'(int'(IRWrite[p]) + int'(memRead[p]) + int'(memWrite[p])), 32'd1);
            chk($sformatf("ready_in_access%0d", p), {30'd0, ifReady[p], dReady[p]}, 32'd0);
            runLen[p]++;
            seenKind[p] = IRWrite[p] ? 1 : (memRead[p] ? 2 : 3);
            seenAddr[p] = address[p];
            seenWd[p]   = writeData[p];
          end
          if (busy[p]) busyRun[p]++;
          if (ifValid[p] || dValid[p]) begin
            have = (p == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (!have) begin
              checks++; errors++;
              $display("FAIL unexpected_valid%0d: got if_valid=%b d_valid=%b required none",
                       p, ifValid[p], dValid[p]);
            end else begin
              e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
              chk($sformatf("who%0d", p), {30'd0, ifValid[p], dValid[p]},
                  e.isIf ? 32'd2 : 32'd1);
              chk($sformatf("data%0d", p), e.isIf ? ifInst[p] : dRdata[p], e.data);
              chk($sformatf("err%0d", p), e.isIf ? 32'(ifErr[p]) : 32'(dErr[p]), 32'(e.err));
              chk($sformatf("strobe_kind%0d", p), 32'(seenKind[p]), 32'(e.kind));
              chk($sformatf("strobe_cycles%0d", p), 32'(runLen[p]), 32'(e.strobeCyc));
              chk($sformatf("busy_cycles%0d", p), 32'(busyRun[p]), 32'(e.busyCyc));
              chk($sformatf("ready_in_resp%0d", p), {30'd0, ifReady[p], dReady[p]}, 32'd0);
              if (e.kind != 0) chk($sformatf("address%0d", p), seenAddr[p], e.addr);
              if (e.kind == 3) chk($sformatf("writeData%0d", p), seenWd[p], e.wdata);
            end
            runLen[p] = 0; busyRun[p] = 0; seenKind[p] = 0;
            respCnt[p]++;
          end
        end
      end
    end
  end

  // Present a request, hold it until accepted, then drop it.
  task automatic reqP(input int p, input bit isIf, input bit we,
                      input logic [31:0] addr, input logic [31:0] wd);
    int t;
    @(negedge clk);
    if (isIf) begin
      ifReq[p] = 1'b1; ifAddr[p] = addr;
    end else begin
      dReq[p] = 1'b1; dWe[p] = we; dAddr[p] = addr; dWdata[p] = wd;
    end
    t = 0;
    while (!(isIf ? ifReady[p] : dReady[p]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout%0d: ready never rose, required within 50 cycles", p);
    end
    @(posedge clk);
    #1;
    ifReq[p] = 1'b0;
    dReq[p]  = 1'b0;
  endtask

  task automatic waitResp(input int p, input int target);
    int t;
    t = 0;
    while (respCnt[p] < target && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (respCnt[p] < target) begin
      checks++; errors++;
      $display("FAIL resp_timeout%0d: got %0d responses required %0d", p, respCnt[p], target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    rstN = 2'b00; preload = 1'b1;
    ifReq = '0; dReq = '0; dWe = '0;
    for (int p = 0; p < 2; p++) begin
      ifAddr[p] = '0; dAddr[p] = '0; dWdata[p] = '0;
    end
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst_ready%0d", p), {30'd0, ifReady[p], dReady[p]}, 32'd0);
      chk($sformatf("rst_strobes%0d", p), {29'd0, IRWrite[p], memRead[p], memWrite[p]}, 32'd0);
      chk($sformatf("rst_busy_valid%0d", p), {29'd0, busy[p], ifValid[p], dValid[p]}, 32'd0);
      chk($sformatf("rst_data%0d", p), ifInst[p] | dRdata[p] | address[p], 32'd0);
    end
    preload = 1'b0;
    rstN = 2'b11;
    @(negedge clk);
    chk("ready_after_reset", {30'd0, ifReady[0], dReady[0]}, 32'd3);

    // Fetch at 16 with MEM_LATENCY = 1.
    pushExp(0, mk(1'b1, 1, 32'd16, 32'd0, 32'h00400020, 1'b0, 1, 2));
    reqP(0, 1'b1, 1'b0, 32'd16, 32'd0);
    waitResp(0, 1);

    // Store then load at 12.
    pushExp(0, mk(1'b0, 3, 32'd12, 32'hDEADBEEF, 32'd0, 1'b0, 1, 2));
    reqP(0, 1'b0, 1'b1, 32'd12, 32'hDEADBEEF);
    waitResp(0, 2);
    pushExp(0, mk(1'b0, 2, 32'd12, 32'd0, 32'hDEADBEEF, 1'b0, 1, 2));
    reqP(0, 1'b0, 1'b0, 32'd12, 32'd0);
    waitResp(0, 3);
    @(negedge clk);
    chk("d_rdata_hold", dRdata[0], 32'hDEADBEEF);
    chk("if_inst_hold", ifInst[0], 32'h00400020);

    // Misaligned load: error response one cycle after accept, data 0.
    pushExp(0, mk(1'b0, 0, 32'd10, 32'd0, 32'd0, 1'b1, 0, 1));
    reqP(0, 1'b0, 1'b0, 32'd10, 32'd0);
    waitResp(0, 4);

    // Contention right after reset: IF, D, IF, D.
    @(negedge clk);
    rstN[0] = 1'b0;
    @(negedge clk);
    rstN[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pushExp(0, mk(1'b1, 1, 32'd16, 32'd0, 32'h00400020, 1'b0, 1, 2));
      pushExp(0, mk(1'b0, 2, 32'd12, 32'd0, 32'hDEADBEEF, 1'b0, 1, 2));
    end
    tgt = respCnt[0] + 4;
    @(negedge clk);
    ifReq[0] = 1'b1; ifAddr[0] = 32'd16;
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'd12;
    waitResp(0, tgt);
    ifReq[0] = 1'b0; dReq[0] = 1'b0;

    // MEM_LATENCY = 3 load at 8.
    pushExp(1, mk(1'b0, 2, 32'd8, 32'd0, 32'h12345678, 1'b0, 3, 4));
    reqP(1, 1'b0, 1'b0, 32'd8, 32'd0);
    waitResp(1, 1);

    // Reset during the second ACCESS cycle of a store.
    reqP(1, 1'b0, 1'b1, 32'd20, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    chk("memWrite_before_reset", 32'(memWrite[1]), 32'd1);
    rstN[1] = 1'b0;
    #1;
    chk("memWrite_async_drop", {30'd0, memWrite[1], busy[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rstN[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_valid_after_abort", 32'(respCnt[1]), 32'd1);

    // Tie after release: fetch goes first.
    pushExp(1, mk(1'b1, 1, 32'd4, 32'd0, 32'hCAFEF00D, 1'b0, 3, 4));
    pushExp(1, mk(1'b0, 2, 32'd8, 32'd0, 32'h12345678, 1'b0, 3, 4));
    ifReq[1] = 1'b1; ifAddr[1] = 32'd4;
    dReq[1] = 1'b1; dWe[1] = 1'b0; dAddr[1] = 32'd8;
    waitResp(1, 3);
    ifReq[1] = 1'b0; dReq[1] = 1'b0;

    repeat (6) @(negedge clk);
    chk("sb_empty0", 32'(sb0.size()), 32'd0);
    chk("sb_empty1", 32'(sb1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
